// File: rtl/seg_scan_capture_if.sv
// Shared bus between a multiplexed active-low 7-segment/anode driver and the capture
// block that reconstructs the displayed digits from it.
interface seg_scan_capture_if;
  logic [6:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] digit_code;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        bad_pattern;
  logic        unknown_glyph;

  // Output semantics: there is no back-pressure. digit_code/digit_valid are levels that
  // hold until the next capture or expiry of that digit; the three pulses are high for
  // exactly one clk cycle and are never repeated for the same event.
  modport master (
    output seg_in, an_in,
    input  digit_code, digit_valid, frame_done, bad_pattern, unknown_glyph
  );

  modport slave (
    input  seg_in, an_in,
    output digit_code, digit_valid, frame_done, bad_pattern, unknown_glyph
  );
endinterface

// File: rtl/seg_scan_capture.sv
// Reads back a time-multiplexed 7-segment display: synchronises the bus, waits for each
// anode/segment pair to settle, decodes the glyph and keeps 8 digits with staleness expiry.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STALE_CYCLES  = 2_000_000
) (
  input  logic              clk,
  input  logic              reset,
  seg_scan_capture_if.slave bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2,
    BAD    = 2'd3
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] STALE_LAST = TW'(STALE_CYCLES - 1);

  logic [6:0]    seg_m, seg_s, seg_p;
  logic [7:0]    an_m, an_s, an_p;
  logic [SW-1:0] stab_cnt;
  state_t        state, state_nxt;

  logic [31:0]   code_r;
  logic [7:0]    valid_r;
  logic [TW-1:0] stale_cnt [8];
  logic [2:0]    last_idx;
  logic          last_seen;
  logic          fd_r, bp_r, ug_r;

  logic          changed, an_idle, an_onehot, capture, glyph_known;
  logic [7:0]    an_low;
  logic [2:0]    cap_idx;
  logic [3:0]    glyph;

  // Idle bus is all ones (active low), so sync and history flops reset to ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_m <= '1; seg_s <= '1; seg_p <= '1;
      an_m  <= '1; an_s  <= '1; an_p  <= '1;
    end else begin
      seg_m <= bus.seg_in; seg_s <= seg_m; seg_p <= seg_s;
      an_m  <= bus.an_in;  an_s  <= an_m;  an_p  <= an_s;
    end
  end

  always_comb begin
    changed   = {an_s, seg_s} != {an_p, seg_p};
    an_idle   = (an_s == 8'hFF);
    an_low    = ~an_s;
    an_onehot = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
    cap_idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (an_low[i]) cap_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab_cnt <= '0;
    end else if (changed) begin
      stab_cnt <= '0;
    end else if (stab_cnt != SETTLE_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // 'S' shares its pattern with 5; code A is never produced.
  always_comb begin
    glyph       = 4'hE;
    glyph_known = 1'b1;
    case (seg_s)
      7'b1000000: glyph = 4'h0;
      7'b1111001: glyph = 4'h1;
      7'b0100100: glyph = 4'h2;
      7'b0110000: glyph = 4'h3;
      7'b0011001: glyph = 4'h4;
      7'b0010010: glyph = 4'h5;
      7'b0000010: glyph = 4'h6;
      7'b1111000: glyph = 4'h7;
      7'b0000000: glyph = 4'h8;
      7'b0010000: glyph = 4'h9;
      7'b0000111: glyph = 4'hB;
      7'b0000110: glyph = 4'hC;
      7'b1111111: glyph = 4'hF;
      default:    glyph_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    if (an_idle) begin
      state_nxt = IDLE;
    end else if (!an_onehot) begin
      state_nxt = BAD;
    end else if (changed) begin
      state_nxt = SETTLE;
    end else if (state == SETTLE && stab_cnt == SETTLE_MAX) begin
      state_nxt = HELD;
      capture   = 1'b1;
    end
  end

  // Capture of a digit takes priority over its own expiry in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_r    <= '1;
      valid_r   <= '0;
      last_idx  <= '0;
      last_seen <= 1'b0;
      fd_r      <= 1'b0;
      bp_r      <= 1'b0;
      ug_r      <= 1'b0;
      for (int i = 0; i < 8; i++) stale_cnt[i] <= '0;
    end else begin
      fd_r <= capture && last_seen && (cap_idx <= last_idx);
      ug_r <= capture && !glyph_known;
      bp_r <= (state_nxt == BAD) && (state != BAD);
      if (capture) begin
        last_idx  <= cap_idx;
        last_seen <= 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        if (capture && cap_idx == 3'(i)) begin
          code_r[4*i +: 4] <= glyph;
          valid_r[i]       <= 1'b1;
          stale_cnt[i]     <= '0;
        end else if (valid_r[i]) begin
          if (stale_cnt[i] == STALE_LAST) begin
            code_r[4*i +: 4] <= 4'hF;
            valid_r[i]       <= 1'b0;
            stale_cnt[i]     <= '0;
          end else begin
            stale_cnt[i] <= stale_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.digit_code    = code_r;
  assign bus.digit_valid   = valid_r;
  assign bus.frame_done    = fd_r;
  assign bus.bad_pattern   = bp_r;
  assign bus.unknown_glyph = ug_r;
  assign state_dbg         = state;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture: expected output events are queued by the stimulus
// and a negedge monitor pops and compares each one the DUT presents, including its cycle.
module tb_seg_scan_capture;
  localparam int S     = 16;
  localparam int STALE = 1000;
  localparam int EW    = 75;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] state_dbg;
  int n_total = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [31:0] mcode;
  logic [7:0] mvalid;
  int c5, c1;

  seg_scan_capture_if bus();

  seg_scan_capture #(.SETTLE_CYCLES(S), .STALE_CYCLES(STALE)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] seg_of(input int g);
    case (g)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Expected cycle 0 means the event may occur at any cycle.
  task automatic push(input int c, input logic [31:0] code, input logic [7:0] v,
                      input logic fd, input logic bp, input logic ug);
    logic [31:0] cw;
    cw = c;
    exp_q.push_back({cw, code, v, fd, bp, ug});
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg);
    @(negedge clk);
    bus.an_in  = an;
    bus.seg_in = seg;
    t0 = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    push(0, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_code", bus.digit_code, 32'hFFFF_FFFF);
    check("rst_valid", bus.digit_valid, 8'h00);
    check("rst_pulses", {bus.frame_done, bus.bad_pattern, bus.unknown_glyph}, 3'b000);
    check("rst_state", state_dbg, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.an_in  = 8'hFF;
    bus.seg_in = 7'h7F;
  endtask

  // Monitor: any change of the digit levels or any pulse is one output event.
  initial begin
    logic [31:0] prev_code;
    logic [7:0]  prev_valid;
    logic [EW-1:0] e;
    logic [31:0] e_cyc;
    logic [42:0] got;
    prev_code  = 32'hFFFF_FFFF;
    prev_valid = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && (bus.digit_code !== prev_code || bus.digit_valid !== prev_valid ||
                     bus.frame_done || bus.bad_pattern || bus.unknown_glyph)) begin
        n_total++;
        got = {bus.digit_code, bus.digit_valid, bus.frame_done, bus.bad_pattern, bus.unknown_glyph};
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d code=%h valid=%h fd/bp/ug=%b", cyc,
                   bus.digit_code, bus.digit_valid, got[2:0]);
        end else begin
          e = exp_q.pop_front();
          e_cyc = e[74:43];
          if (got !== e[42:0] || (e_cyc != 0 && e_cyc != cyc)) begin
            n_bad++;
            $display("FAIL event got cyc=%0d code=%h valid=%h fd/bp/ug=%b want cyc=%0d code=%h valid=%h fd/bp/ug=%b",
                     cyc, got[42:11], got[10:3], got[2:0], e_cyc, e[42:11], e[10:3], e[2:0]);
          end
        end
      end
      prev_code  = bus.digit_code;
      prev_valid = bus.digit_valid;
    end
  end

  initial begin
    reset = 1'b1;
    bus.an_in  = 8'hFF;
    bus.seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    #1;
    check("init_code", bus.digit_code, 32'hFFFF_FFFF);
    check("init_valid", bus.digit_valid, 8'h00);
    check("init_pulses", {bus.frame_done, bus.bad_pattern, bus.unknown_glyph}, 3'b000);
    check("init_state", state_dbg, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    hold(3);

    // Single digit 3 on digit 0: capture exactly S+3 edges after the first sampling edge.
    drive(8'hFE, 7'b0110000);
    push(t0 + S + 4, 32'hFFFF_FFF3, 8'h01, 1'b0, 1'b0, 1'b0);
    hold(S + 10);
    drive(8'hFF, 7'h7F);
    hold(5);
    do_reset();
    hold(3);

    // Two full scans of glyphs 0..7; only the second scan's digit 0 wraps.
    mcode  = 32'hFFFF_FFFF;
    mvalid = 8'h00;
    for (int sc = 0; sc < 2; sc++) begin
      for (int d = 0; d < 8; d++) begin
        drive(~(8'h01 << d), seg_of(d));
        if (sc == 0) begin
          mcode[4*d +: 4] = 4'(d);
          mvalid[d] = 1'b1;
          push(t0 + S + 4, mcode, mvalid, 1'b0, 1'b0, 1'b0);
        end else if (d == 0) begin
          push(t0 + S + 4, 32'h7654_3210, 8'hFF, 1'b1, 1'b0, 1'b0);
        end
        hold(S + 10);
      end
    end
    drive(8'hFF, 7'h7F);
    hold(5);
    do_reset();
    hold(3);

    // Segments never stable long enough on digit 2: nothing captured.
    drive(8'hFB, seg_of(2));
    for (int k = 0; k < 8; k++) begin
      hold(S - 3);
      drive(8'hFB, seg_of((k % 2 == 0) ? 3 : 2));
    end
    hold(S - 3);
    drive(8'hFF, 7'h7F);
    hold(5);
    check("no_capture_valid", bus.digit_valid, 8'h00);

    // Two anodes low for 50 cycles: one bad_pattern pulse on entry, no digit writes.
    drive(8'hFC, 7'b0000000);
    push(t0 + 3, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, 1'b0);
    hold(49);
    drive(8'hFF, 7'h7F);
    hold(5);

    // Unknown segment pattern on digit 5 decodes to E and still marks the digit valid.
    drive(8'hDF, 7'b0101010);
    c5 = t0 + S + 4;
    push(c5, 32'hFFEF_FFFF, 8'h20, 1'b0, 1'b0, 1'b1);
    hold(S + 10);

    // Digit 1 after digit 5 wraps; both then expire STALE cycles after capture.
    drive(8'hFD, 7'b1111001);
    c1 = t0 + S + 4;
    push(c1, 32'hFFEF_FF1F, 8'h22, 1'b1, 1'b0, 1'b0);
    push(c5 + STALE, 32'hFFFF_FF1F, 8'h02, 1'b0, 1'b0, 1'b0);
    push(c1 + STALE, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 1'b0);
    hold(S + 10);
    drive(8'hFF, 7'h7F);
    hold(STALE + 40);
    check("stale_digit1", {bus.digit_code[7:4], bus.digit_valid[1]}, 5'b1111_0);

    // Restart a scan, then reset while digit 1 is still settling.
    drive(8'hFE, 7'b0000000);
    push(t0 + S + 4, 32'hFFFF_FFF8, 8'h01, 1'b1, 1'b0, 1'b0);
    hold(S + 10);
    drive(8'hFD, 7'b0010000);
    hold(5);
    do_reset();
    hold(S + 20);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
